if_id_decode: RTL and testbench
===============================

Name: if_id_decode

Overview:
- IF/ID pipeline register plus field decoder for the 5-stage MIPS core.
- Registers the fetched instruction and PC, then splits out the register, shift, function and immediate fields.
- Drives the immediate and the Unsigned select into the downstream Sign_Extend block.
- Detects load-use hazards against EX, stalls IF, and absorbs branch flushes from EX.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle performance counter.
- RESET_PC, 32'h0000_0000, value loaded into id_pc on reset.

Ports:
- clk  in  1  single clock for the block; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  IF is presenting a valid instruction this cycle.
- if_pc  in  32  PC of the fetched instruction.
- if_instr  in  32  fetched instruction word.
- flush  in  1  branch/jump taken in EX; kill the ID contents.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- stall  out  1  hold PC and IF outputs this cycle (combinational).
- id_issue  out  1  ID hands a valid instruction to EX this cycle (combinational).
- id_valid  out  1  ID register holds a valid instruction.
- id_pc  out  32  registered PC.
- id_instr  out  32  registered instruction.
- opcode  out  6  id_instr[31:26].
- rs  out  5  id_instr[25:21].
- rt  out  5  id_instr[20:16].
- rd  out  5  id_instr[15:11].
- shamt  out  5  id_instr[10:6].
- funct  out  6  id_instr[5:0].
- imm16  out  16  id_instr[15:0]; connects to Sign_Extend "in".
- imm_unsigned  out  1  connects to Sign_Extend "Unsigned".
- stall_cnt  out  CNT_W  count of cycles with stall=1; saturates at all-ones.

Behaviour:
- Reset:
  - id_valid=0, id_instr=0, id_pc=RESET_PC, stall_cnt=0.
  - Field outputs follow id_instr, so all are 0. stall=0 and id_issue=0, because id_valid=0.
- Field outputs are pure slices of the id_instr register: zero extra latency after capture.
- imm_unsigned=1 when opcode is 0x0C (ANDI), 0x0D (ORI), 0x0E (XORI) or 0x0F (LUI); 0 for all other opcodes, including ADDIU and SLTIU.
- uses_rt=1 when opcode is 0x00 (R-type), 0x04, 0x05 (BEQ/BNE), 0x28, 0x29 or 0x2B (stores); 0 otherwise.
- hazard = id_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==rs) | (uses_rt & ex_rt==rt)).
- stall = hazard & ~flush.
- id_issue = id_valid & ~stall & ~flush.
- Register update at each rising edge, priority order:
  1. reset.
  2. flush: id_valid<=0, id_instr<=0; id_pc holds.
  3. stall: all ID registers hold.
  4. Otherwise capture: id_valid<=if_valid, id_pc<=if_pc, id_instr <= if_valid ? if_instr : 0.
- Latency: an instruction presented at edge N appears on the ID outputs after edge N; each stall adds one cycle.
- A stall lasts exactly one cycle for a given load: EX receives a bubble (id_issue=0), so the next cycle's ex_mem_read is 0 from upstream.
- Simultaneous flush and hazard: flush wins; stall=0, and the stall counter does not increment.
- stall_cnt increments on every cycle with stall=1 and stops at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall: the next edge clears state regardless of hazard or flush.
- if_valid=0 while not stalled: a bubble (id_valid=0) is loaded, and no hazard can be raised from it.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SB, OP_SH, OP_SW;
  - field-position constants;
  - NOP_INSTR = 32'h0.
- One natural sub-module, hazard_unit: purely combinational hazard, stall and id_issue logic. It is reused later for the forwarding checks.

Test Plan:
- Reset: assert reset for 2 cycles with if_valid=1, if_instr=32'h2062FFFF -> id_valid=0, id_instr=0, stall=0, stall_cnt=0, id_pc=RESET_PC.
- Immediate decode:
  - if_instr=32'h30628000 (ANDI $2,$3,0x8000) -> opcode=0x0C, rs=3, rt=2, imm16=16'h8000, imm_unsigned=1.
  - Next, 32'h2062FFFF (ADDI) -> imm16=16'hFFFF, imm_unsigned=0.
- Load-use on rs: ID holds 32'h010B5020 (ADD $10,$8,$11), ex_mem_read=1, ex_rt=8 -> stall=1, id_issue=0, ID holds for one cycle, stall_cnt=1. Then ex_mem_read=0 -> stall=0, id_issue=1.
- Load-use via rt:
  - ID holds 32'hAD280004 (SW $8,4($9)) with ex_rt=8, ex_mem_read=1 -> stall=1.
  - ID holds 32'h20680001 (ADDI $8,$3,1) with ex_rt=8 -> stall=0, because rt is not a source.
  - ex_rt=0 with any instruction -> stall=0.
- Flush priority: hazard conditions active and flush=1 together -> stall=0, id_issue=0. After the edge: id_valid=0, id_instr=0, stall_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive hazard cycles -> stall_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and the source-operand
// and immediate-signedness classifiers used by the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Logical immediates zero-extend; ADDIU/SLTIU still sign-extend.
  function automatic logic imm_is_unsigned(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

  // rt is a read operand only for R-type, branches and stores.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection for the instruction held in ID; purely combinational.
// A taken branch in EX overrides the stall since the ID instruction is being killed anyway.
module hazard_unit
  import mips_pkg::*;
(
  input  logic       id_valid_i,
  input  logic       flush_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [5:0] opcode_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       stall_o,
  output logic       issue_o
);

  logic hazard;

  assign hazard  = id_valid_i && ex_mem_read_i && (ex_rt_i != 5'd0) &&
                   ((ex_rt_i == rs_i) || (uses_rt(opcode_i) && (ex_rt_i == rt_i)));
  assign stall_o = hazard && !flush_i;
  assign issue_o = id_valid_i && !stall_o && !flush_i;

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register and field decoder; fields are slices of the ID register (no added latency).
// A load-use hazard holds ID and stalls IF for one cycle; a flush empties ID and wins over stall.
module if_id_decode
  import mips_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             stall,
  output logic             id_issue,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic             imm_unsigned,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_instr     = id_instr_q;
  assign stall_cnt    = stall_cnt_q;
  assign opcode       = id_instr_q[OPCODE_LSB +: 6];
  assign rs           = id_instr_q[RS_LSB +: 5];
  assign rt           = id_instr_q[RT_LSB +: 5];
  assign rd           = id_instr_q[RD_LSB +: 5];
  assign shamt        = id_instr_q[SHAMT_LSB +: 5];
  assign funct        = id_instr_q[FUNCT_LSB +: 6];
  assign imm16        = id_instr_q[IMM_LSB +: 16];
  assign imm_unsigned = imm_is_unsigned(opcode);

  hazard_unit u_hazard (
    .id_valid_i    (id_valid_q),
    .flush_i       (flush),
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .opcode_i      (opcode),
    .rs_i          (rs),
    .rt_i          (rt),
    .stall_o       (stall),
    .issue_o       (id_issue)
  );

  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (!stall) begin
      id_valid_d = if_valid;
      id_pc_d    = if_pc;
      id_instr_d = if_valid ? if_instr : NOP_INSTR;
    end
    // Saturate rather than wrap so a long run still reads as "at least this many".
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q  <= 1'b0;
      id_pc_q     <= RESET_PC;
      id_instr_q  <= NOP_INSTR;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_decode.sv
// Directed bench for if_id_decode: decode, load-use stalls, flush priority, bubbles,
// counter saturation (2-bit counter) and reset during a stall.
module tb_if_id_decode;

  localparam int          CNT_W    = 2;
  localparam logic [31:0] RST_PC   = 32'h0040_0000;

  logic             clk = 1'b0;
  logic             reset, if_valid, flush, ex_mem_read;
  logic [31:0]      if_pc, if_instr;
  logic [4:0]       ex_rt;
  logic             stall, id_issue, id_valid, imm_unsigned;
  logic [31:0]      id_pc, id_instr;
  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      imm16;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_decode #(.CNT_W(CNT_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .stall(stall), .id_issue(id_issue), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .imm_unsigned(imm_unsigned), .stall_cnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may then be changed and outputs sampled 2-3 time units later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h2062FFFF;
    flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    step(); step(); #1;
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_instr", id_instr, 0);
    check_eq("rst_pc", id_pc, RST_PC);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_issue", id_issue, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    check_eq("rst_opcode", opcode, 0);

    // ANDI $2,$3,0x8000
    reset = 1'b0; if_pc = 32'h104; if_instr = 32'h30628000;
    step(); #1;
    check_eq("andi_valid", id_valid, 1);
    check_eq("andi_pc", id_pc, 32'h104);
    check_eq("andi_opcode", opcode, 32'h0C);
    check_eq("andi_rs", rs, 3);
    check_eq("andi_rt", rt, 2);
    check_eq("andi_imm", imm16, 32'h8000);
    check_eq("andi_uns", imm_unsigned, 1);
    check_eq("andi_issue", id_issue, 1);

    // ADDI sign-extends
    if_pc = 32'h108; if_instr = 32'h2062FFFF;
    step(); #1;
    check_eq("addi_opcode", opcode, 32'h08);
    check_eq("addi_imm", imm16, 32'hFFFF);
    check_eq("addi_uns", imm_unsigned, 0);

    // ADD $10,$8,$11 with load of $8 in EX
    if_pc = 32'h10C; if_instr = 32'h010B5020;
    step();
    check_eq("add_rd", rd, 10);
    check_eq("add_funct", funct, 32'h20);
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    if_pc = 32'h110; if_instr = 32'hAD280004;
    #1;
    check_eq("lu_rs_stall", stall, 1);
    check_eq("lu_rs_issue", id_issue, 0);
    step();
    ex_mem_read = 1'b0;
    #1;
    check_eq("lu_rs_hold_instr", id_instr, 32'h010B5020);
    check_eq("lu_rs_hold_pc", id_pc, 32'h10C);
    check_eq("lu_rs_cnt", stall_cnt, 1);
    check_eq("lu_rs_release_stall", stall, 0);
    check_eq("lu_rs_release_issue", id_issue, 1);

    // SW $8,4($9): rt is a source
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    #1;
    check_eq("sw_instr", id_instr, 32'hAD280004);
    check_eq("sw_stall", stall, 1);
    step();
    ex_mem_read = 1'b0;
    if_pc = 32'h114; if_instr = 32'h20680001;
    #1;
    check_eq("sw_cnt", stall_cnt, 2);

    // ADDI $8,$3,1: rt is a destination, no hazard
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    #1;
    check_eq("addi_rt_instr", id_instr, 32'h20680001);
    check_eq("addi_rt_stall", stall, 0);
    check_eq("addi_rt_issue", id_issue, 1);

    // ADD $10,$0,$0 against a load of $0
    ex_mem_read = 1'b0;
    if_pc = 32'h118; if_instr = 32'h00005020;
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd0;
    #1;
    check_eq("zero_rt_stall", stall, 0);
    check_eq("zero_rt_issue", id_issue, 1);

    // Flush together with a hazard
    ex_mem_read = 1'b0;
    if_pc = 32'h11C; if_instr = 32'h010B5020;
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd8; flush = 1'b1;
    if_pc = 32'h120; if_instr = 32'h30628000;
    #1;
    check_eq("flush_stall", stall, 0);
    check_eq("flush_issue", id_issue, 0);
    step();
    flush = 1'b0; ex_mem_read = 1'b0;
    #1;
    check_eq("flush_valid", id_valid, 0);
    check_eq("flush_instr", id_instr, 0);
    check_eq("flush_pc", id_pc, 32'h11C);
    check_eq("flush_cnt", stall_cnt, 2);

    // Bubble from IF cannot raise a hazard
    if_valid = 1'b0; if_pc = 32'h124; if_instr = 32'h010B5020;
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    #1;
    check_eq("bubble_valid", id_valid, 0);
    check_eq("bubble_instr", id_instr, 0);
    check_eq("bubble_pc", id_pc, 32'h124);
    check_eq("bubble_stall", stall, 0);

    // Saturation of the 2-bit counter
    reset = 1'b1; ex_mem_read = 1'b0;
    step();
    reset = 1'b0; if_valid = 1'b1; if_pc = 32'h200; if_instr = 32'h010B5020;
    #1;
    check_eq("sat_cnt0", stall_cnt, 0);
    step();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check_eq($sformatf("sat_cnt%0d", i + 1), stall_cnt, (i < 2) ? i + 1 : 3);
    end
    check_eq("sat_hold_pc", id_pc, 32'h200);

    // Reset during a stall, with flush also raised
    reset = 1'b1; flush = 1'b1;
    step(); #1;
    check_eq("midrst_valid", id_valid, 0);
    check_eq("midrst_pc", id_pc, RST_PC);
    check_eq("midrst_cnt", stall_cnt, 0);
    check_eq("midrst_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
